qar_uart_rx: RTL and testbench

Receive front end for the QAR-Core UART/RS-485 path. It oversamples the serial `rx` line, deframes 8N1 characters, detects framing errors and line-idle events, and buffers received bytes in a small FIFO. The core's UART register block drains that FIFO through a valid/ready handshake. The block sits between the transceiver receive pin (or the `uart_tx` loopback) and the core's UART data/status registers.

---
 rtl/qar_uart_rx_if.sv | 9 +
 rtl/qar_uart_rx.sv | 177 +++++++++++++++++
 tb/tb_qar_uart_rx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/qar_uart_rx_if.sv
// Drain handshake between the UART receive FIFO and the core's UART register block.
interface qar_uart_rx_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (output rx_valid, output rx_data, input rx_ready);
    modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/qar_uart_rx.sv
// 8N1 UART receiver: 2-FF input synchronizer, mid-bit sampling deframer,
// receive FIFO with valid/ready drain, sticky framing/overrun/idle status.
module qar_uart_rx #(
    parameter int DIV_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int IDLE_BITS  = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [DIV_WIDTH-1:0]        baud_div,
    input  logic                        rx,
    qar_uart_rx_if.master               rx_if,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        overrun,
    output logic                        idle_flag,
    input  logic                        clr_status
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = DIV_WIDTH + $clog2(IDLE_BITS + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    state_e               state_q, state_d;
    logic                 sync_q, sync_d, rxs_q, rxs_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           mem_q [FIFO_DEPTH];
    logic [7:0]           mem_d [FIFO_DEPTH];
    logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]        count_q, count_d;
    logic [IW-1:0]        idle_cnt_q, idle_cnt_d;
    logic                 armed_q, armed_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 idle_q, idle_d;

    logic [DIV_WIDTH-1:0] div_eff;
    logic [IW-1:0]        idle_target;
    logic                 expire, push, frame_set, pop, full, accept, idle_set;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        sync_d      = rx;
        rxs_d       = sync_q;
        div_eff     = (baud_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : baud_div;
        idle_target = IW'(IDLE_BITS) * IW'(div_eff);

        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
        expire    = (cnt_q <= DIV_WIDTH'(1));
        if (state_q != S_IDLE) cnt_d = cnt_q - DIV_WIDTH'(1);

        case (state_q)
            S_IDLE: begin
                if (enable && !rxs_q) begin
                    cnt_d   = div_eff >> 1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (expire) begin
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = div_eff;
                        bit_d   = 3'd0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (expire) begin
                    shift_d = {rxs_q, shift_q[7:1]};
                    cnt_d   = div_eff;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            S_STOP: begin
                if (expire) begin
                    push      = rxs_q;
                    frame_set = !rxs_q;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (!enable) begin
            state_d   = S_IDLE;
            push      = 1'b0;
            frame_set = 1'b0;
        end

        // A full FIFO still accepts when the head is popped on the same edge.
        full    = (count_q == CW'(FIFO_DEPTH));
        pop     = (count_q != '0) && rx_if.rx_ready;
        accept  = push && (!full || pop);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        if (accept) begin
            mem_d[wr_q] = shift_q;
            wr_d        = wr_q + PW'(1);
        end
        if (pop) rd_d = rd_q + PW'(1);
        count_d = count_q + CW'(accept) - CW'(pop);

        idle_cnt_d = idle_cnt_q;
        if (!enable || state_q != S_IDLE || !rxs_q) idle_cnt_d = '0;
        else if (idle_cnt_q < idle_target)         idle_cnt_d = idle_cnt_q + IW'(1);
        idle_set = armed_q && (idle_cnt_d == idle_target) && (idle_cnt_d != '0);

        armed_d = armed_q;
        if (accept)        armed_d = 1'b1;
        else if (idle_set) armed_d = 1'b0;
        if (!enable)       armed_d = 1'b0;

        frame_err_d = frame_set | (frame_err_q & ~clr_status);
        overrun_d   = (push && full && !pop) | (overrun_q & ~clr_status);
        idle_d      = idle_set | (idle_q & ~clr_status);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sync_q      <= 1'b1;
            rxs_q       <= 1'b1;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            idle_cnt_q  <= '0;
            armed_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            idle_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            rxs_q       <= rxs_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
            idle_cnt_q  <= idle_cnt_d;
            armed_q     <= armed_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            idle_q      <= idle_d;
        end
    end

    // NOTE: storage is deliberately not reset; rx_data is gated to zero while empty instead.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rx_if.rx_valid = (count_q != '0);
    assign rx_if.rx_data  = rx_if.rx_valid ? mem_q[rd_q] : 8'h00;
    assign fifo_count     = count_q;
    assign frame_err      = frame_err_q;
    assign overrun        = overrun_q;
    assign idle_flag      = idle_q;
endmodule

// File: tb/tb_qar_uart_rx.sv
// Directed bench for qar_uart_rx at baud_div=16, FIFO_DEPTH=4, IDLE_BITS=10.
module tb_qar_uart_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        rx = 1'b1;
    logic        clr_status = 1'b0;
    logic [15:0] baud_div = 16'd16;
    logic [2:0]  fifo_count;
    logic        frame_err, overrun, idle_flag;
    int          total = 0;
    int          bad = 0;

    qar_uart_rx_if bus ();

    qar_uart_rx #(.DIV_WIDTH(16), .FIFO_DEPTH(4), .IDLE_BITS(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .baud_div   (baud_div),
        .rx         (rx),
        .rx_if      (bus),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .idle_flag  (idle_flag),
        .clr_status (clr_status)
    );

    always #5 clk = ~clk;

    // All stimulus stays aligned to 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; rx = 1'b1; enable = 1'b1; clr_status = 1'b0; bus.rx_ready = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        rx = 1'b0;
        tick(int'(baud_div));
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            tick(int'(baud_div));
        end
        rx = stop_bit;
        tick(int'(baud_div));
        rx = 1'b1;
    endtask

    task automatic pop_byte(output logic v, output logic [7:0] d);
        v = bus.rx_valid;
        d = bus.rx_data;
        bus.rx_ready = 1'b1;
        tick(1);
        bus.rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid); end
        total++; if (bus.rx_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", bus.rx_data); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        total++; if ({frame_err, overrun, idle_flag} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {frame_err, overrun, idle_flag}); end
    endtask

    task automatic test_single_byte();
        logic v; logic [7:0] d;
        apply_reset();
        send_frame(8'h33, 1'b1);
        total++; if (bus.rx_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", bus.rx_valid); end
        total++; if (bus.rx_data !== 8'h33) begin bad++; $display("FAIL single_data: got %h want 33", bus.rx_data); end
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL single_count: got %0d want 1", fifo_count); end
        total++; if ({frame_err, overrun, idle_flag} !== 3'b000) begin bad++; $display("FAIL single_flags: got %b want 000", {frame_err, overrun, idle_flag}); end
        pop_byte(v, d);
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid: got %b want 0", bus.rx_valid); end
    endtask

    task automatic test_back_to_back();
        logic v; logic [7:0] d;
        apply_reset();
        send_frame(8'h33, 1'b1);
        send_frame(8'h55, 1'b1);
        tick(2);
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL b2b_count: got %0d want 2", fifo_count); end
        pop_byte(v, d);
        total++; if ({v, d} !== {1'b1, 8'h33}) begin bad++; $display("FAIL b2b_pop0: got v=%b d=%h want v=1 d=33", v, d); end
        pop_byte(v, d);
        total++; if ({v, d} !== {1'b1, 8'h55}) begin bad++; $display("FAIL b2b_pop1: got v=%b d=%h want v=1 d=55", v, d); end
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty: got %b want 0", bus.rx_valid); end
    endtask

    task automatic test_glitch();
        apply_reset();
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(60);
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL glitch_count: got %0d want 0", fifo_count); end
        total++; if ({frame_err, overrun} !== 2'b00) begin bad++; $display("FAIL glitch_flags: got %b want 00", {frame_err, overrun}); end
        send_frame(8'hC3, 1'b1);
        total++; if (bus.rx_data !== 8'hC3 || fifo_count !== 3'd1) begin bad++; $display("FAIL glitch_recover: got data=%h count=%0d want C3/1", bus.rx_data, fifo_count); end
    endtask

    task automatic test_framing();
        apply_reset();
        send_frame(8'hA5, 1'b0);
        tick(20);
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL frame_set: got %b want 1", frame_err); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL frame_count: got %0d want 0", fifo_count); end
        clr_status = 1'b1;
        tick(1);
        clr_status = 1'b0;
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL frame_clear: got %b want 0", frame_err); end
    endtask

    task automatic test_overrun();
        logic v; logic [7:0] d;
        apply_reset();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        tick(2);
        total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovr_count: got %0d want 4", fifo_count); end
        for (int i = 1; i <= 4; i++) begin
            pop_byte(v, d);
            total++; if ({v, d} !== {1'b1, 8'(i)}) begin bad++; $display("FAIL ovr_pop%0d: got v=%b d=%h want v=1 d=%h", i, v, d, 8'(i)); end
        end
        total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL ovr_empty: got %b want 0", bus.rx_valid); end

        // Fifth push lands 155 edges after its start bit is driven; pop on that same edge.
        apply_reset();
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        fork
            send_frame(8'h05, 1'b1);
            begin
                tick(154);
                bus.rx_ready = 1'b1;
                tick(1);
                bus.rx_ready = 1'b0;
            end
        join
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_coinc_flag: got %b want 0", overrun); end
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL ovr_coinc_count: got %0d want 4", fifo_count); end
        for (int i = 2; i <= 5; i++) begin
            pop_byte(v, d);
            total++; if ({v, d} !== {1'b1, 8'(i)}) begin bad++; $display("FAIL ovr_coinc_pop%0d: got v=%b d=%h want v=1 d=%h", i, v, d, 8'(i)); end
        end
    endtask

    task automatic test_idle();
        apply_reset();
        send_frame(8'h0A, 1'b1);
        // Stop sample was 5 edges before send_frame returned; flag due 160 edges after it.
        tick(154);
        total++; if (idle_flag !== 1'b0) begin bad++; $display("FAIL idle_early: got %b want 0", idle_flag); end
        tick(1);
        total++; if (idle_flag !== 1'b1) begin bad++; $display("FAIL idle_on_time: got %b want 1", idle_flag); end
        total++; if (bus.rx_data !== 8'h0A) begin bad++; $display("FAIL idle_data: got %h want 0A", bus.rx_data); end
        clr_status = 1'b1;
        tick(1);
        clr_status = 1'b0;
        tick(300);
        total++; if (idle_flag !== 1'b0) begin bad++; $display("FAIL idle_once: got %b want 0", idle_flag); end
    endtask

    task automatic test_enable();
        apply_reset();
        fork
            send_frame(8'h00, 1'b1);
            begin
                tick(40);
                enable = 1'b0;
                tick(140);
                enable = 1'b1;
            end
        join
        tick(200);
        total++; if ({fifo_count, frame_err, idle_flag} !== 5'b0) begin bad++; $display("FAIL enable_abort: got count=%0d fe=%b idle=%b want 0/0/0", fifo_count, frame_err, idle_flag); end
        send_frame(8'h81, 1'b1);
        total++; if (bus.rx_data !== 8'h81 || fifo_count !== 3'd1) begin bad++; $display("FAIL enable_recover: got data=%h count=%0d want 81/1", bus.rx_data, fifo_count); end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        send_frame(8'h33, 1'b1);
        rx = 1'b0; tick(16);
        rx = 1'b1; tick(16);
        rx = 1'b0; tick(8);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        rx = 1'b1;
        total++; if (bus.rx_valid !== 1'b0 || bus.rx_data !== 8'h00) begin bad++; $display("FAIL rstmid_out: got v=%b d=%h want 0/00", bus.rx_valid, bus.rx_data); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
        total++; if ({frame_err, overrun, idle_flag} !== 3'b000) begin bad++; $display("FAIL rstmid_flags: got %b want 000", {frame_err, overrun, idle_flag}); end
        tick(40);
        send_frame(8'h55, 1'b1);
        tick(2);
        total++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 8'h55) begin bad++; $display("FAIL rstmid_rx: got v=%b d=%h want 1/55", bus.rx_valid, bus.rx_data); end
        total++; if (fifo_count !== 3'd1 || frame_err !== 1'b0) begin bad++; $display("FAIL rstmid_status: got count=%0d fe=%b want 1/0", fifo_count, frame_err); end
    endtask

    initial begin
        bus.rx_ready = 1'b0;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_overrun();
        test_idle();
        test_enable();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
